fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Instruction-fetch front end that sits directly upstream of the single-cycle core's decode and execute path.
- Generates sequential word addresses, issues them to an instruction memory through a request handshake, and buffers in-order responses in a small FIFO.
- Presents {pc, instruction} pairs downstream with a valid/ready handshake.
- On a redirect (branch or jalr), flushes buffered and in-flight instructions and restarts fetch at the new target.

Parameters:
- DEPTH, 4: FIFO entries and the maximum in-flight requests (buffered + outstanding ≤ DEPTH); power of two, ≥ 2.
- RESET_PC, 32'h0000_0000: first fetch address after reset.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous, active-low.
- imem_req_valid  output  1  fetch request valid.
- imem_req_addr  output  32  word-aligned fetch address; bits [1:0] are always 0.
- imem_req_ready  input  1  memory accepts the request this cycle.
- imem_resp_valid  input  1  response data valid; in-order; latency ≥ 1 cycle; no back-pressure.
- imem_resp_data  input  32  instruction word.
- redirect_valid  input  1  single-cycle flush-and-restart pulse.
- redirect_pc  input  32  restart address; bits [1:0] are ignored (treated as 0).
- inst_valid  output  1  FIFO head valid.
- inst_data  output  32  FIFO head instruction.
- inst_pc  output  32  FIFO head pc.
- inst_ready  input  1  consumer accepts the head.

Behaviour:
- Reset (rst low, asynchronous):
  - fetch_pc = resp_pc = RESET_PC.
  - FIFO count, rd/wr pointers, outstanding and discard counters = 0.
  - inst_valid = 0, imem_req_valid = 0.
  - inst_data and inst_pc read 0 while the FIFO is empty.
- Counters: count, outstanding and discard are each $clog2(DEPTH+1) bits wide.
- Request side:
  - imem_req_valid = rst && !redirect_valid && (count + outstanding < DEPTH).
  - imem_req_addr = fetch_pc.
  - req_fire = imem_req_valid && imem_req_ready; on req_fire, fetch_pc += 4 (wraps modulo 2^32) and outstanding += 1.
  - imem_req_valid must not depend on imem_req_ready.
- Response side:
  - On imem_resp_valid, outstanding -= 1.
  - If discard != 0: the response is dropped and discard -= 1.
  - Otherwise: push {resp_pc, imem_resp_data} into the FIFO and resp_pc += 4.
  - The credit rule guarantees the FIFO is never full on a kept response. A response arriving with outstanding == 0 is a protocol violation; assert on it in simulation.
- Output side:
  - inst_valid = (count != 0); inst_data and inst_pc come from the head entry and are registered storage, not bypassed.
  - Pop on inst_valid && inst_ready.
  - A response pushed in cycle t is first visible at the output in cycle t+1.
  - Simultaneous push and pop leaves count unchanged.
  - Head fields must remain stable while inst_valid && !inst_ready.
- Latency and throughput:
  - Request in cycle t with 1-cycle memory → response in t+1 → inst_valid in t+2.
  - With DEPTH ≥ 4, 1-cycle memory and inst_ready held high, throughput is one instruction per cycle.
- Redirect (redirect_valid high in cycle t):
  - No request issues in cycle t.
  - A pop in cycle t still completes; then the FIFO is flushed: count = 0, pointers reset.
  - fetch_pc = resp_pc = {redirect_pc[31:2], 2'b00}.
  - discard = outstanding − (imem_resp_valid ? 1 : 0). Any response arriving in cycle t belongs to the old stream and is dropped.
  - Fetch resumes in t+1: outstanding discards still consume credit, so requests may issue if the credit rule allows.
  - Back-to-back redirects: each recomputes discard from the live outstanding count; the last target wins.
- Reset mid-operation clears all state immediately. The instruction memory shares rst, so it must not return pre-reset responses.
- No FSM beyond these counters. An implementation with an explicit IDLE/FETCH/DRAIN encoding is acceptable if externally equivalent.

Test Plan:
- Cold start, 1-cycle memory returning 0x00000013 + addr, inst_ready=1:
  - Requests to 0x0, 0x4, 0x8, … in consecutive cycles.
  - First inst_valid 2 cycles after rst release with inst_pc=0x0; one instruction per cycle thereafter.
- Back-pressure, inst_ready=0 for 10 cycles:
  - Exactly 4 requests issued; imem_req_valid stays 0 afterwards.
  - Head stays pc 0x0 with stable data.
  - After inst_ready=1, pcs 0x0, 0x4, 0x8, 0xC are delivered in order, then fetch resumes.
- Redirect with 3 outstanding (memory latency 3), redirect_pc=0x103:
  - The 3 stale responses are dropped and the FIFO is emptied.
  - Next request address is 0x100; first delivered inst_pc=0x100.
- Redirect coinciding with imem_resp_valid and an inst_valid&&inst_ready pop:
  - The pop completes and the response is dropped.
  - discard = outstanding−1; no stale pc ever appears on inst_pc.
- Address wrap: redirect_pc=0xFFFFFFFC → delivered pcs are 0xFFFFFFFC, 0x00000000, 0x00000004.
- Asynchronous reset asserted mid-stream, between clock edges:
  - inst_valid and imem_req_valid drop immediately.
  - After release, fetch restarts at RESET_PC with all counters at 0.

Source files
------------

// File: rtl/fetch_queue_if.sv
// Fetch-queue signal bundle: instruction-memory request/response, redirect, and the
// downstream {pc, instruction} handshake. "master" is the fetch queue, "slave" its environment.
interface fetch_queue_if;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready;

  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc,
           inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
    output imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc,
           inst_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: sequential word fetch with credit-limited in-flight requests,
// an in-order response FIFO, and flush-and-restart on redirect.
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic           clk,
  input logic           rst,
  fetch_queue_if.master bus
);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [CW:0] DepthW = (CW + 1)'(DEPTH);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   data_mem [DEPTH];

  logic [CW:0]   in_use;
  logic          req_fire;
  logic          push;
  logic          pop;
  logic [31:0]   target;

  // Buffered plus outstanding never exceeds DEPTH, so a kept response always finds a slot.
  assign in_use   = {1'b0, count_q} + {1'b0, outstanding_q};
  assign target   = {bus.redirect_pc[31:2], 2'b00};

  assign bus.imem_req_valid = rst && !bus.redirect_valid && (in_use < DepthW);
  assign bus.imem_req_addr  = fetch_pc_q;
  assign bus.inst_valid     = (count_q != '0);
  assign bus.inst_data      = bus.inst_valid ? data_mem[rd_ptr_q] : '0;
  assign bus.inst_pc        = bus.inst_valid ? pc_mem[rd_ptr_q] : '0;

  assign req_fire = bus.imem_req_valid && bus.imem_req_ready;
  assign pop      = bus.inst_valid && bus.inst_ready;
  assign push     = bus.imem_resp_valid && (discard_q == '0) && !bus.redirect_valid;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    count_d       = count_q + CW'(push) - CW'(pop);
    outstanding_d = outstanding_q + CW'(req_fire) - CW'(bus.imem_resp_valid);
    discard_d     = discard_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;

    if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
    if (pop)      rd_ptr_d   = rd_ptr_q + PW'(1);
    if (push) begin
      wr_ptr_d  = wr_ptr_q + PW'(1);
      resp_pc_d = resp_pc_q + 32'd4;
    end
    if (bus.imem_resp_valid && (discard_q != '0)) discard_d = discard_q - CW'(1);

    // A same-cycle response belongs to the old stream, so it is not counted as a discard.
    if (bus.redirect_valid) begin
      fetch_pc_d = target;
      resp_pc_d  = target;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      discard_d  = outstanding_q - CW'(bus.imem_resp_valid);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      count_q       <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]   <= resp_pc_q;
      data_mem[wr_ptr_q] <= bus.imem_resp_data;
    end
  end

`ifndef SYNTHESIS
  resp_needs_outstanding: assert property (@(posedge clk) disable iff (!rst)
    bus.imem_resp_valid |-> (outstanding_q != '0));
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed vector table, corner-case sequences, and randomized traffic
// checked against a queue-based model of the fetch stream.
module tb_fetch_queue;
  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk;
  logic rst;
  fetch_queue_if bus ();

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;
  typedef struct {
    bit rb; bit rdy; bit rv; logic [31:0] addr; bit iv; logic [31:0] pc;
  } vec_t;

  mreq_t       mq[$];        // memory: accepted requests awaiting response
  ent_t        m_fifo[$];    // model: instructions visible downstream
  bit          m_inflight[$]; // model: requests in flight, 1 = belongs to a flushed stream
  logic [31:0] m_fetch_pc, m_resp_pc;
  logic [31:0] got_pcs[$];
  int          cyc, lat_min, lat_max;
  int          tests, fails;
  logic        s_rv, s_iv;
  logic [31:0] s_addr, s_pc, s_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic check_got(input string name, input int idx, input logic [31:0] exp);
    check(name, (got_pcs.size() > idx) ? got_pcs[idx] : 32'hxxxx_xxxx, exp);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = '0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = '0;
    bus.inst_ready      = 1'b0;
    mq.delete();
    m_fifo.delete();
    m_inflight.delete();
    got_pcs.delete();
    m_fetch_pc = RESET_PC;
    m_resp_pc  = RESET_PC;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    cyc = 0;
  endtask

  // One clock cycle: drive, sample mid-cycle against the model, advance the model and memory.
  task automatic step(input bit rdy, input bit mready, input bit redir, input logic [31:0] rpc);
    bit          resp, exp_rv, exp_iv, fire, stale;
    logic [31:0] rdata;
    resp  = (mq.size() > 0) && (mq[0].due <= cyc);
    rdata = resp ? mq[0].addr + 32'h13 : $urandom;
    bus.inst_ready      = rdy;
    bus.imem_req_ready  = mready;
    bus.redirect_valid  = redir;
    bus.redirect_pc     = rpc;
    bus.imem_resp_valid = resp;
    bus.imem_resp_data  = rdata;
    #1;
    s_rv = bus.imem_req_valid; s_addr = bus.imem_req_addr;
    s_iv = bus.inst_valid; s_pc = bus.inst_pc; s_data = bus.inst_data;
    exp_rv = !redir && ((m_fifo.size() + m_inflight.size()) < int'(DEPTH));
    exp_iv = (m_fifo.size() != 0);
    check("req_valid", {31'b0, s_rv}, {31'b0, exp_rv});
    if (exp_rv) check("req_addr", s_addr, m_fetch_pc);
    check("inst_valid", {31'b0, s_iv}, {31'b0, exp_iv});
    if (exp_iv) begin
      check("inst_pc", s_pc, m_fifo[0].pc);
      check("inst_data", s_data, m_fifo[0].data);
    end else begin
      check("empty_pc", s_pc, 32'h0);
      check("empty_data", s_data, 32'h0);
    end
    fire = exp_rv && mready;
    if (exp_iv && rdy) begin
      got_pcs.push_back(m_fifo[0].pc);
      void'(m_fifo.pop_front());
    end
    if (resp) begin
      void'(mq.pop_front());
      stale = m_inflight.pop_front();
      if (!stale && !redir) begin
        m_fifo.push_back('{pc: m_resp_pc, data: rdata});
        m_resp_pc = m_resp_pc + 32'd4;
      end
    end
    if (redir) begin
      m_fifo.delete();
      foreach (m_inflight[i]) m_inflight[i] = 1'b1;
      m_fetch_pc = {rpc[31:2], 2'b00};
      m_resp_pc  = {rpc[31:2], 2'b00};
    end
    if (fire) begin
      m_inflight.push_back(1'b0);
      mq.push_back('{addr: m_fetch_pc, due: cyc + int'($urandom_range(lat_max, lat_min))});
      m_fetch_pc = m_fetch_pc + 32'd4;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  vec_t vecs [20];

  initial begin
    tests = 0;
    fails = 0;
    lat_min = 1;
    lat_max = 1;
    // Cold start (0-4), then back-pressure from a fresh reset (5-19), 1-cycle memory.
    vecs = '{
      '{1, 1, 1, 32'h00, 0, 32'h00}, '{0, 1, 1, 32'h04, 0, 32'h00},
      '{0, 1, 1, 32'h08, 1, 32'h00}, '{0, 1, 1, 32'h0C, 1, 32'h04},
      '{0, 1, 1, 32'h10, 1, 32'h08},
      '{1, 0, 1, 32'h00, 0, 32'h00}, '{0, 0, 1, 32'h04, 0, 32'h00},
      '{0, 0, 1, 32'h08, 1, 32'h00}, '{0, 0, 1, 32'h0C, 1, 32'h00},
      '{0, 0, 0, 32'h00, 1, 32'h00}, '{0, 0, 0, 32'h00, 1, 32'h00},
      '{0, 0, 0, 32'h00, 1, 32'h00}, '{0, 0, 0, 32'h00, 1, 32'h00},
      '{0, 0, 0, 32'h00, 1, 32'h00}, '{0, 0, 0, 32'h00, 1, 32'h00},
      '{0, 1, 0, 32'h00, 1, 32'h00}, '{0, 1, 1, 32'h10, 1, 32'h04},
      '{0, 1, 1, 32'h14, 1, 32'h08}, '{0, 1, 1, 32'h18, 1, 32'h0C},
      '{0, 1, 1, 32'h1C, 1, 32'h10}
    };

    rst = 1'b0;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      if (vecs[i].rb) do_reset();
      step(vecs[i].rdy, 1'b1, 1'b0, 32'h0);
      check($sformatf("vec%0d_rv", i), {31'b0, s_rv}, {31'b0, vecs[i].rv});
      if (vecs[i].rv) check($sformatf("vec%0d_addr", i), s_addr, vecs[i].addr);
      check($sformatf("vec%0d_iv", i), {31'b0, s_iv}, {31'b0, vecs[i].iv});
      if (vecs[i].iv) begin
        check($sformatf("vec%0d_pc", i), s_pc, vecs[i].pc);
        check($sformatf("vec%0d_data", i), s_data, vecs[i].pc + 32'h13);
      end
    end

    // Redirect with three requests outstanding on a 4-cycle memory.
    do_reset();
    lat_min = 4; lat_max = 4;
    repeat (3) step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 32'h0000_0103);
    check("redir_no_issue", {31'b0, s_rv}, 32'h0);
    got_pcs.delete();
    step(1'b1, 1'b1, 1'b0, 32'h0);
    check("redir_next_addr", s_addr, 32'h0000_0100);
    repeat (14) step(1'b1, 1'b1, 1'b0, 32'h0);
    check_got("redir_first_pc", 0, 32'h0000_0100);

    // Redirect coinciding with a response and a pop on a 1-cycle memory.
    do_reset();
    lat_min = 1; lat_max = 1;
    repeat (6) step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 32'h0000_0200);
    check("coincide_pop", {31'b0, s_iv}, 32'h1);
    got_pcs.delete();
    repeat (8) step(1'b1, 1'b1, 1'b0, 32'h0);
    check_got("coincide_first_pc", 0, 32'h0000_0200);
    check_got("coincide_second_pc", 1, 32'h0000_0204);

    // Address wrap.
    step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
    got_pcs.delete();
    repeat (8) step(1'b1, 1'b1, 1'b0, 32'h0);
    check_got("wrap_pc0", 0, 32'hFFFF_FFFC);
    check_got("wrap_pc1", 1, 32'h0000_0000);
    check_got("wrap_pc2", 2, 32'h0000_0004);

    // Asynchronous reset between clock edges.
    repeat (3) step(1'b0, 1'b1, 1'b0, 32'h0);
    #2;
    rst = 1'b0;
    #1;
    check("async_req_valid", {31'b0, bus.imem_req_valid}, 32'h0);
    check("async_inst_valid", {31'b0, bus.inst_valid}, 32'h0);
    do_reset();
    step(1'b1, 1'b1, 1'b0, 32'h0);
    check("post_reset_addr", s_addr, RESET_PC);
    check("post_reset_rv", {31'b0, s_rv}, 32'h1);
    repeat (6) step(1'b1, 1'b1, 1'b0, 32'h0);

    // Randomized traffic with variable memory latency.
    do_reset();
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(9, 0) < 7), ($urandom_range(3, 0) != 0),
           ($urandom_range(99, 0) < 3), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
